// File: rtl/spi_mem_arbiter.sv
// spi_mem_arbiter
// Round-robin arbiter that shares one SPI memory controller between the CPU
// instruction-fetch port and the load/store data port. It runs the
// controller's level-held start/done handshake. After each transaction it
// inserts an idle gap. It rejects unmapped addresses and illegal data sizes,
// and a watchdog aborts any transaction that the controller never completes.
`timescale 1ns/1ps

module spi_mem_arbiter #(
   parameter int TIMEOUT_CYCLES = 200,
   parameter int GAP_CYCLES     = 1
) (
   input  logic        clk,
   input  logic        rst,

   // instruction-fetch port
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_ack,
   output logic [31:0] if_rdata,
   output logic        if_err,

   // load/store port
   input  logic        d_req,
   input  logic        d_we,
   input  logic [2:0]  d_size,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_ack,
   output logic [31:0] d_rdata,
   output logic        d_err,

   // SPI memory controller
   output logic        mem_start_request,
   output logic [31:0] mem_target_address,
   output logic [2:0]  mem_num_bytes,
   output logic        mem_is_write,
   output logic [31:0] mem_write_value,
   input  logic [31:0] mem_fetched_data,
   input  logic        mem_request_done,

   output logic        busy
);

   localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

   localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

   // Port identifiers, used for both the round-robin pointer and the owner
   localparam logic PORT_F = 1'b0;
   localparam logic PORT_D = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   // ------------------------------------------------------------------
   // State and registered outputs
   // ------------------------------------------------------------------
   state_t             state_q,     state_d;
   logic               rr_ptr_q,    rr_ptr_d;
   logic               owner_q,     owner_d;
   logic [WD_W-1:0]    wdog_q,      wdog_d;
   logic [GAP_W-1:0]   gap_q,       gap_d;

   logic               mem_start_q, mem_start_d;
   logic [31:0]        mem_addr_q,  mem_addr_d;
   logic [2:0]         mem_nb_q,    mem_nb_d;
   logic               mem_we_q,    mem_we_d;
   logic [31:0]        mem_wval_q,  mem_wval_d;

   logic               if_ack_q,    if_ack_d;
   logic [31:0]        if_rdata_q,  if_rdata_d;
   logic               if_err_q,    if_err_d;
   logic               d_ack_q,     d_ack_d;
   logic [31:0]        d_rdata_q,   d_rdata_d;
   logic               d_err_q,     d_err_d;
   logic               busy_q,      busy_d;

   // ------------------------------------------------------------------
   // Arbitration and request validation (combinational view of IDLE)
   // ------------------------------------------------------------------
   logic gnt_any;
   logic gnt_sel;
   logic fetch_ok;
   logic data_ok;
   logic gnt_ok;

   // Only the 0x00 and 0x01 top-byte windows are backed by SPI memory
   function automatic logic addr_mapped(input logic [7:0] top);
      return (top == 8'h00) || (top == 8'h01);
   endfunction

   function automatic logic size_legal(input logic [2:0] sz);
      return (sz == 3'd1) || (sz == 3'd2) || (sz == 3'd4);
   endfunction

   // Pick the requester: a lone request wins outright, a tie goes to rr_ptr
   always_comb begin
      gnt_any  = if_req | d_req;
      gnt_sel  = (if_req && d_req) ? rr_ptr_q : d_req;
      fetch_ok = addr_mapped(if_addr[31:24]);
      data_ok  = addr_mapped(d_addr[31:24]) && size_legal(d_size);
      gnt_ok   = (gnt_sel == PORT_D) ? data_ok : fetch_ok;
   end

   // ------------------------------------------------------------------
   // Next-state and output logic
   // ------------------------------------------------------------------
   logic        resp_fire;
   logic        resp_err;
   logic [31:0] resp_data;

   // FSM transitions, controller field loading and response generation
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      owner_d     = owner_q;
      wdog_d      = wdog_q;
      gap_d       = gap_q;

      mem_start_d = mem_start_q;
      mem_addr_d  = mem_addr_q;
      mem_nb_d    = mem_nb_q;
      mem_we_d    = mem_we_q;
      mem_wval_d  = mem_wval_q;

      resp_fire   = 1'b0;
      resp_err    = 1'b0;
      resp_data   = 32'h0;

      unique case (state_q)
         ST_IDLE: begin
            if (gnt_any) begin
               owner_d  = gnt_sel;
               rr_ptr_d = ~gnt_sel;
               if (gnt_ok) begin
                  // Load the controller fields from the winner and start
                  if (gnt_sel == PORT_D) begin
                     mem_addr_d = d_addr;
                     mem_nb_d   = d_size;
                     mem_we_d   = d_we;
                     mem_wval_d = d_wdata;
                  end else begin
                     mem_addr_d = if_addr;
                     mem_nb_d   = 3'd4;
                     mem_we_d   = 1'b0;
                     mem_wval_d = 32'h0;
                  end
                  mem_start_d = 1'b1;
                  wdog_d      = '0;
                  state_d     = ST_ISSUE;
               end else begin
                  // Rejected without ever touching the controller
                  resp_fire = 1'b1;
                  resp_err  = 1'b1;
                  gap_d     = '0;
                  state_d   = ST_GAP;
               end
            end
         end

         ST_ISSUE: begin
            if (mem_request_done) begin
               // Done takes priority over a simultaneous watchdog expiry
               resp_fire   = 1'b1;
               resp_data   = mem_we_q ? 32'h0 : mem_fetched_data;
               mem_start_d = 1'b0;
               gap_d       = '0;
               state_d     = ST_GAP;
            end else if (wdog_q == WD_LAST) begin
               resp_fire   = 1'b1;
               resp_err    = 1'b1;
               mem_start_d = 1'b0;
               gap_d       = '0;
               state_d     = ST_GAP;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
         end

         ST_GAP: begin
            if (gap_q == GAP_LAST) begin
               state_d = ST_IDLE;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end

         default: begin
            state_d     = ST_IDLE;
            mem_start_d = 1'b0;
         end
      endcase

      // Steer the single response to whichever port owns the transaction
      if_ack_d   = resp_fire && (owner_d == PORT_F);
      if_err_d   = resp_fire && (owner_d == PORT_F) && resp_err;
      if_rdata_d = (resp_fire && (owner_d == PORT_F)) ? resp_data : 32'h0;
      d_ack_d    = resp_fire && (owner_d == PORT_D);
      d_err_d    = resp_fire && (owner_d == PORT_D) && resp_err;
      d_rdata_d  = (resp_fire && (owner_d == PORT_D)) ? resp_data : 32'h0;

      busy_d     = (state_d != ST_IDLE);
   end

   // ------------------------------------------------------------------
   // Register update; reset abandons any transaction without an ack
   // ------------------------------------------------------------------
   // State, counters and all registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         rr_ptr_q    <= PORT_F;
         owner_q     <= PORT_F;
         wdog_q      <= '0;
         gap_q       <= '0;
         mem_start_q <= 1'b0;
         mem_addr_q  <= 32'h0;
         mem_nb_q    <= 3'd0;
         mem_we_q    <= 1'b0;
         mem_wval_q  <= 32'h0;
         if_ack_q    <= 1'b0;
         if_rdata_q  <= 32'h0;
         if_err_q    <= 1'b0;
         d_ack_q     <= 1'b0;
         d_rdata_q   <= 32'h0;
         d_err_q     <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         owner_q     <= owner_d;
         wdog_q      <= wdog_d;
         gap_q       <= gap_d;
         mem_start_q <= mem_start_d;
         mem_addr_q  <= mem_addr_d;
         mem_nb_q    <= mem_nb_d;
         mem_we_q    <= mem_we_d;
         mem_wval_q  <= mem_wval_d;
         if_ack_q    <= if_ack_d;
         if_rdata_q  <= if_rdata_d;
         if_err_q    <= if_err_d;
         d_ack_q     <= d_ack_d;
         d_rdata_q   <= d_rdata_d;
         d_err_q     <= d_err_d;
         busy_q      <= busy_d;
      end
   end

   assign if_ack             = if_ack_q;
   assign if_rdata           = if_rdata_q;
   assign if_err             = if_err_q;
   assign d_ack              = d_ack_q;
   assign d_rdata            = d_rdata_q;
   assign d_err              = d_err_q;
   assign mem_start_request  = mem_start_q;
   assign mem_target_address = mem_addr_q;
   assign mem_num_bytes      = mem_nb_q;
   assign mem_is_write       = mem_we_q;
   assign mem_write_value    = mem_wval_q;
   assign busy               = busy_q;

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// tb_spi_mem_arbiter
// Directed bench for spi_mem_arbiter. The bench plays the SPI controller by
// hand and checks every response against hand-computed values. Inputs change
// and outputs are sampled on the falling clock edge.
`timescale 1ns/1ps

module tb_spi_mem_arbiter;

   localparam int TIMEOUT = 200;
   localparam int GAP     = 1;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_ack;
   logic [31:0] if_rdata;
   logic        if_err;
   logic        d_req;
   logic        d_we;
   logic [2:0]  d_size;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_ack;
   logic [31:0] d_rdata;
   logic        d_err;
   logic        mem_start_request;
   logic [31:0] mem_target_address;
   logic [2:0]  mem_num_bytes;
   logic        mem_is_write;
   logic [31:0] mem_write_value;
   logic [31:0] mem_fetched_data;
   logic        mem_request_done;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   spi_mem_arbiter #(
      .TIMEOUT_CYCLES (TIMEOUT),
      .GAP_CYCLES     (GAP)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .if_req             (if_req),
      .if_addr            (if_addr),
      .if_ack             (if_ack),
      .if_rdata           (if_rdata),
      .if_err             (if_err),
      .d_req              (d_req),
      .d_we               (d_we),
      .d_size             (d_size),
      .d_addr             (d_addr),
      .d_wdata            (d_wdata),
      .d_ack              (d_ack),
      .d_rdata            (d_rdata),
      .d_err              (d_err),
      .mem_start_request  (mem_start_request),
      .mem_target_address (mem_target_address),
      .mem_num_bytes      (mem_num_bytes),
      .mem_is_write       (mem_is_write),
      .mem_write_value    (mem_write_value),
      .mem_fetched_data   (mem_fetched_data),
      .mem_request_done   (mem_request_done),
      .busy               (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end else begin
         $display("ok   %s: 0x%08h", tag, obs);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Count falling edges until the controller start is seen, bounded
   task automatic wait_start(output int n);
      n = 0;
      while (mem_start_request !== 1'b1 && n < 500) begin
         tick();
         n++;
      end
      check("start_seen", mem_start_request, 1);
   endtask

   task automatic apply_reset();
      rst              = 1'b1;
      if_req           = 1'b0;
      if_addr          = 32'h0;
      d_req            = 1'b0;
      d_we             = 1'b0;
      d_size           = 3'd0;
      d_addr           = 32'h0;
      d_wdata          = 32'h0;
      mem_fetched_data = 32'h0;
      mem_request_done = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   // A load/store request that must be rejected without reaching memory
   task automatic illegal_data(input string tag, input logic [31:0] addr, input logic [2:0] size);
      d_addr = addr;
      d_size = size;
      d_we   = 1'b0;
      d_req  = 1'b1;
      tick();
      check({tag, "_ack"},   d_ack, 1);
      check({tag, "_err"},   d_err, 1);
      check({tag, "_rdata"}, d_rdata, 32'h0);
      check({tag, "_nostart"}, mem_start_request, 0);
      d_req = 1'b0;
      tick();
      check({tag, "_pulse"}, d_ack, 0);
      check({tag, "_nostart2"}, mem_start_request, 0);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got stuck expected finish");
      $fatal(1, "bench did not terminate");
   end

   initial begin
      int n;
      logic exp_d;
      logic [31:0] data;

      // ---------------- reset state ----------------
      rst              = 1'b1;
      if_req           = 1'b0;
      if_addr          = 32'h0;
      d_req            = 1'b0;
      d_we             = 1'b0;
      d_size           = 3'd0;
      d_addr           = 32'h0;
      d_wdata          = 32'h0;
      mem_fetched_data = 32'h0;
      mem_request_done = 1'b0;
      tick();
      tick();
      check("rst_start", mem_start_request, 0);
      check("rst_addr",  mem_target_address, 32'h0);
      check("rst_busy",  busy, 0);
      check("rst_acks",  {30'h0, if_ack, d_ack}, 32'h0);
      check("rst_rdata", if_rdata | d_rdata, 32'h0);
      rst = 1'b0;
      tick();

      // ---------------- fetch, done after 40 cycles ----------------
      if_addr = 32'h0000_0010;
      if_req  = 1'b1;
      tick();
      check("f_start",  mem_start_request, 1);
      check("f_addr",   mem_target_address, 32'h0000_0010);
      check("f_nbytes", mem_num_bytes, 4);
      check("f_iswr",   mem_is_write, 0);
      check("f_busy",   busy, 1);
      repeat (39) tick();
      check("f_hold", mem_start_request, 1);
      check("f_noack", if_ack, 0);
      mem_request_done = 1'b1;
      mem_fetched_data = 32'hDEAD_BEEF;
      tick();
      mem_request_done = 1'b0;
      mem_fetched_data = 32'h0;
      if_req = 1'b0;
      check("f_ack",   if_ack, 1);
      check("f_rdata", if_rdata, 32'hDEAD_BEEF);
      check("f_err",   if_err, 0);
      check("f_dack",  d_ack, 0);
      check("f_drop",  mem_start_request, 0);
      tick();
      check("f_pulse", if_ack, 0);
      tick();
      check("f_idle", busy, 0);

      // ---------------- simultaneous requests, alternation ----------------
      apply_reset();
      if_addr = 32'h0000_1000;
      d_addr  = 32'h0100_2000;
      d_we    = 1'b0;
      d_size  = 3'd4;
      if_req  = 1'b1;
      d_req   = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wait_start(n);
         if (i == 0) check("rr_latency", n, 1);
         else        check("rr_b2b_gap", n, GAP + 1);
         exp_d = (i % 2) == 1;
         check("rr_grant_addr", mem_target_address, exp_d ? 32'h0100_2000 : 32'h0000_1000);
         data = 32'hA000_0000 + i;
         mem_request_done = 1'b1;
         mem_fetched_data = data;
         tick();
         mem_request_done = 1'b0;
         mem_fetched_data = 32'h0;
         check("rr_if_ack", if_ack, !exp_d);
         check("rr_d_ack",  d_ack,  exp_d);
         check("rr_rdata",  exp_d ? d_rdata : if_rdata, data);
      end
      if_req = 1'b0;
      d_req  = 1'b0;
      tick();
      tick();
      check("rr_idle", busy, 0);

      // ---------------- store ----------------
      d_addr  = 32'h0100_0004;
      d_size  = 3'd2;
      d_we    = 1'b1;
      d_wdata = 32'h0000_ABCD;
      d_req   = 1'b1;
      tick();
      check("st_start",  mem_start_request, 1);
      check("st_addr",   mem_target_address, 32'h0100_0004);
      check("st_iswr",   mem_is_write, 1);
      check("st_nbytes", mem_num_bytes, 2);
      check("st_wval",   mem_write_value, 32'h0000_ABCD);
      mem_request_done = 1'b1;
      mem_fetched_data = 32'hFFFF_FFFF;
      tick();
      mem_request_done = 1'b0;
      mem_fetched_data = 32'h0;
      d_req = 1'b0;
      d_we  = 1'b0;
      check("st_ack",   d_ack, 1);
      check("st_rdata", d_rdata, 32'h0);
      check("st_err",   d_err, 0);
      check("st_ifack", if_ack, 0);
      tick();
      tick();

      // ---------------- illegal requests ----------------
      illegal_data("bad_addr", 32'h0200_0000, 3'd4);
      illegal_data("bad_size", 32'h0100_0000, 3'd3);
      if_addr = 32'h0300_0000;
      if_req  = 1'b1;
      tick();
      check("bad_f_ack", if_ack, 1);
      check("bad_f_err", if_err, 1);
      check("bad_f_nostart", mem_start_request, 0);
      if_req = 1'b0;
      tick();
      tick();

      // ---------------- watchdog timeout ----------------
      if_addr = 32'h0000_0020;
      if_req  = 1'b1;
      tick();
      check("to_start", mem_start_request, 1);
      repeat (TIMEOUT - 1) tick();
      check("to_not_early", if_ack, 0);
      check("to_still_on",  mem_start_request, 1);
      tick();
      if_req = 1'b0;
      check("to_ack",   if_ack, 1);
      check("to_err",   if_err, 1);
      check("to_rdata", if_rdata, 32'h0);
      check("to_drop",  mem_start_request, 0);
      tick();
      tick();

      // ---------------- done on the timeout cycle ----------------
      if_addr = 32'h0000_0024;
      if_req  = 1'b1;
      tick();
      repeat (TIMEOUT - 1) tick();
      mem_request_done = 1'b1;
      mem_fetched_data = 32'h5A5A_5A5A;
      tick();
      mem_request_done = 1'b0;
      mem_fetched_data = 32'h0;
      if_req = 1'b0;
      check("tod_ack",   if_ack, 1);
      check("tod_err",   if_err, 0);
      check("tod_rdata", if_rdata, 32'h5A5A_5A5A);
      tick();
      tick();

      // ---------------- reset mid-transaction ----------------
      if_addr = 32'h0000_0030;
      if_req  = 1'b1;
      tick();
      repeat (4) tick();
      check("mr_start", mem_start_request, 1);
      rst    = 1'b1;
      if_req = 1'b0;
      tick();
      check("mr_drop",  mem_start_request, 0);
      check("mr_noack", if_ack, 0);
      check("mr_busy",  busy, 0);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("mr_quiet", {30'h0, if_ack, d_ack}, 32'h0);
      end
      if_addr = 32'h0000_0040;
      if_req  = 1'b1;
      tick();
      check("mr_new_start", mem_start_request, 1);
      check("mr_new_addr",  mem_target_address, 32'h0000_0040);
      mem_request_done = 1'b1;
      mem_fetched_data = 32'hCAFE_F00D;
      tick();
      mem_request_done = 1'b0;
      mem_fetched_data = 32'h0;
      if_req = 1'b0;
      check("mr_new_ack",   if_ack, 1);
      check("mr_new_rdata", if_rdata, 32'hCAFE_F00D);
      tick();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
